// File: rtl/vga_fetch_ctrl.sv
// Raster timing and background-ROM address sequencer for the display path.
// Coordinates and syncs are delayed to line up with the ROM data word.
module vga_fetch_ctrl #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 64,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 200,
  parameter int unsigned V_ACTIVE   = 800,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 24,
  parameter int unsigned BORDER     = 10,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned IMG_W      = 315,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [10:0]       draw_x,
  output logic [9:0]        draw_y,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DLY     = ROM_LAT + 1;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HI_BEG  = 11'(BORDER);
  localparam logic [10:0] HI_END  = 11'(H_ACTIVE - BORDER - 1);

  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VI_BEG  = 10'(BORDER);
  localparam logic [9:0]  VI_END  = 10'(V_ACTIVE - BORDER - 1);

  localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;
  localparam logic [SCALE_LOG2-1:0] SUB_ONE = SCALE_LOG2'(1);
  localparam logic [ADDR_W-1:0]     IMG_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]     ADDR_ONE = ADDR_W'(1);

  typedef struct packed {
    logic        fs;
    logic        vs;
    logic        hs;
    logic        act;
    logic [9:0]  y;
    logic [10:0] x;
  } tap_t;

  localparam tap_t TAP_RST = '{fs: 1'b0, vs: 1'b1, hs: 1'b1, act: 1'b0, y: '0, x: '0};

  logic [10:0]             hcnt_q, hcnt_d;
  logic [9:0]              vcnt_q, vcnt_d;
  logic [SCALE_LOG2-1:0]   sub_x_q, sub_x_d;
  logic [SCALE_LOG2-1:0]   sub_y_q, sub_y_d;
  logic [ADDR_W-1:0]       row_base_q, row_base_d;
  logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]       rom_addr_q;
  tap_t                    tap_d;
  tap_t                    pipe_q [DLY];

  logic h_wrap, f_wrap;
  logic in_line, in_px, line_end, last_line;

  always_comb begin
    h_wrap = (hcnt_q == H_LAST);
    f_wrap = h_wrap && (vcnt_q == V_LAST);
    hcnt_d = h_wrap ? '0 : hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_comb begin
    in_line   = (vcnt_q >= VI_BEG) && (vcnt_q <= VI_END);
    in_px     = in_line && (hcnt_q >= HI_BEG) && (hcnt_q <= HI_END);
    line_end  = in_line && (hcnt_q == HI_END);
    last_line = (vcnt_q == VI_END);
  end

  // cur_addr_q is the address of the pixel at (hcnt_q, vcnt_q); rom_addr_q
  // registers it once more, which is the first stage of the alignment delay.
  always_comb begin
    sub_x_d    = sub_x_q;
    sub_y_d    = sub_y_q;
    row_base_d = row_base_q;
    cur_addr_d = cur_addr_q;
    if (f_wrap) begin
      sub_x_d    = '0;
      sub_y_d    = '0;
      row_base_d = '0;
      cur_addr_d = '0;
    end else if (line_end) begin
      sub_x_d = '0;
      // The final interior line holds its address so the frame never steps past the image.
      if (!last_line) begin
        if (sub_y_q == SUB_MAX) begin
          sub_y_d    = '0;
          row_base_d = row_base_q + IMG_STEP;
          cur_addr_d = row_base_q + IMG_STEP;
        end else begin
          sub_y_d    = sub_y_q + SUB_ONE;
          cur_addr_d = row_base_q;
        end
      end
    end else if (in_px) begin
      sub_x_d = sub_x_q + SUB_ONE;
      if (sub_x_q == SUB_MAX) begin
        cur_addr_d = cur_addr_q + ADDR_ONE;
      end
    end
  end

  always_comb begin
    tap_d     = TAP_RST;
    tap_d.x   = hcnt_q;
    tap_d.y   = vcnt_q;
    tap_d.act = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    tap_d.hs  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    tap_d.vs  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    tap_d.fs  = (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      sub_x_q    <= '0;
      sub_y_q    <= '0;
      row_base_q <= '0;
      cur_addr_q <= '0;
      rom_addr_q <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      sub_x_q    <= sub_x_d;
      sub_y_q    <= sub_y_d;
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      rom_addr_q <= cur_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DLY; i++) begin
        pipe_q[i] <= TAP_RST;
      end
    end else begin
      pipe_q[0] <= tap_d;
      for (int unsigned i = 1; i < DLY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign draw_x      = pipe_q[DLY-1].x;
  assign draw_y      = pipe_q[DLY-1].y;
  assign active      = pipe_q[DLY-1].act;
  assign hsync       = pipe_q[DLY-1].hs;
  assign vsync       = pipe_q[DLY-1].vs;
  assign frame_start = pipe_q[DLY-1].fs;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Directed bench: full 1280x800 timing for the first lines, plus a reduced
// raster (ROM_LAT = 2) for whole-frame, address and mid-frame reset behaviour.
module tb_vga_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f_n, rst_s_n;
  logic [15:0] addr_f, addr_s;
  logic [10:0] x_f, x_s;
  logic [9:0]  y_f, y_s;
  logic        act_f, act_s, hs_f, hs_s, vs_f, vs_s, fs_f, fs_s;

  vga_fetch_ctrl u_full (
    .clk(clk), .rst_n(rst_f_n), .rom_addr(addr_f), .draw_x(x_f), .draw_y(y_f),
    .active(act_f), .hsync(hs_f), .vsync(vs_f), .frame_start(fs_f)
  );

  // Reduced raster: H_TOTAL = 55, V_TOTAL = 30, interior x 2..37, y 2..21,
  // 9 words per image row, 5 image rows, last address 44.
  vga_fetch_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(24), .V_FP(1), .V_SYNC(3), .V_BP(2),
    .BORDER(2), .SCALE_LOG2(2), .IMG_W(9), .ROM_LAT(2), .ADDR_W(16)
  ) u_small (
    .clk(clk), .rst_n(rst_s_n), .rom_addr(addr_s), .draw_x(x_s), .draw_y(y_s),
    .active(act_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_addr(input int x, input int y, input int b, input int s, input int w);
    return ((y - b) >> s) * w + ((x - b) >> s);
  endfunction

  task automatic check_idle(input string t, input logic [15:0] a, input logic [10:0] x,
                            input logic [9:0] y, input logic act, input logic hs,
                            input logic vs, input logic fs);
    check({t, "_addr"}, a, 0);
    check({t, "_x"}, x, 0);
    check({t, "_y"}, y, 0);
    check({t, "_active"}, act, 0);
    check({t, "_hsync"}, hs, 1);
    check({t, "_vsync"}, vs, 1);
    check({t, "_fstart"}, fs, 0);
  endtask

  // Reduced-raster scan state; rom_addr pairs with draw coords ROM_LAT = 2 samples later.
  logic [15:0] h1, h2;
  int sb_pix, sb_bad, fs_cnt, fs_c0, fs_c1, fs_off, vs_low, vs_first_y, last_addr, first2, max_addr;

  task automatic release_small(input string t);
    rst_s_n = 1'b1;
    @(negedge clk); h2 = addr_s; check({t, "_fs_lag1"}, fs_s, 0);
    @(negedge clk); h1 = addr_s; check({t, "_fs_lag2"}, fs_s, 0);
    @(negedge clk);
    check({t, "_fs"}, fs_s, 1);
    check({t, "_fs_x"}, x_s, 0);
    check({t, "_fs_y"}, y_s, 0);
    check({t, "_fs_act"}, act_s, 1);
  endtask

  task automatic scan_small(input int ncyc);
    sb_pix = 0; sb_bad = 0; fs_cnt = 0; fs_c0 = -1; fs_c1 = -1; fs_off = 0;
    vs_low = 0; vs_first_y = -1; last_addr = -1; first2 = -1; max_addr = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (fs_s) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_c0 = c;
        if (fs_cnt == 2) fs_c1 = c;
        if (x_s != 0 || y_s != 0) fs_off++;
      end
      if (!vs_s) begin
        vs_low++;
        if (vs_first_y < 0) vs_first_y = int'(y_s);
      end
      if (act_s && x_s >= 2 && x_s <= 37 && y_s >= 2 && y_s <= 21) begin
        sb_pix++;
        if (int'(h2) != model_addr(int'(x_s), int'(y_s), 2, 2, 9)) sb_bad++;
      end
      if (x_s == 37 && y_s == 21) last_addr = int'(h2);
      if (x_s == 2 && y_s == 2 && fs_cnt == 2) first2 = int'(h2);
      if (int'(addr_s) > max_addr) max_addr = int'(addr_s);
      h2 = h1;
      h1 = addr_s;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, hs_low, hs_x0, act_cnt, line_per, f_pix, f_bad;
    logic [15:0] prev_f;
    int px [9] = '{10, 13, 14, 17, 1266, 1269, 10, 1269, 10};
    int py [9] = '{10, 10, 10, 10, 10,   10,   11, 13,   14};
    int pe [9] = '{0,  0,  1,  1,  314,  314,  0,  314,  315};
    int found;

    rst_f_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst_full", addr_f, x_f, y_f, act_f, hs_f, vs_f, fs_f);
    check_idle("rst_small", addr_s, x_s, y_s, act_s, hs_s, vs_s, fs_s);

    // Full-size raster, ROM_LAT = 1: frame_start two clocks after release.
    rst_f_n = 1'b1;
    @(negedge clk);
    check("full_fs_lag1", fs_f, 0);
    prev_f = addr_f;
    @(negedge clk);
    check("full_fs", fs_f, 1);
    check("full_fs_x", x_f, 0);
    check("full_fs_y", y_f, 0);
    check("full_fs_act", act_f, 1);

    c = 0; hs_low = 0; hs_x0 = -1; act_cnt = 0; line_per = -1; f_pix = 0; f_bad = 0;
    while (c < 1680 * 16 && y_f != 15) begin
      if (y_f == 0) begin
        if (!hs_f) begin
          hs_low++;
          if (hs_x0 < 0) hs_x0 = int'(x_f);
        end
        if (act_f) act_cnt++;
      end
      if (x_f == 0 && y_f == 1 && line_per < 0) line_per = c;
      if (act_f && y_f >= 10 && x_f >= 10 && x_f <= 1269) begin
        f_pix++;
        if (int'(prev_f) != model_addr(int'(x_f), int'(y_f), 10, 2, 315)) f_bad++;
      end
      for (int i = 0; i < 9; i++) begin
        if (int'(x_f) == px[i] && int'(y_f) == py[i])
          check($sformatf("full_addr_%0d_%0d", px[i], py[i]), prev_f, pe[i]);
      end
      prev_f = addr_f;
      @(negedge clk);
      c++;
    end
    check("full_reach_y15", y_f, 15);
    check("full_hs_low_len", hs_low, 136);
    check("full_hs_start_x", hs_x0, 1344);
    check("full_active_len", act_cnt, 1280);
    check("full_line_period", line_per, 1680);
    check("full_sb_pix", f_pix, 1260 * 5);
    check("full_sb_bad", f_bad, 0);

    // Reduced raster: two complete frames from reset.
    release_small("small");
    scan_small(2 * 1650);
    check("small_fs_count", fs_cnt, 2);
    check("small_frame_period", fs_c1 - fs_c0, 1650);
    check("small_fs_offpixel", fs_off, 0);
    check("small_vs_low", vs_low, 2 * 3 * 55);
    check("small_vs_first_y", vs_first_y, 25);
    check("small_sb_pix", sb_pix, 2 * 36 * 20);
    check("small_sb_bad", sb_bad, 0);
    check("small_last_addr", last_addr, 44);
    check("small_max_addr", max_addr, 44);
    check("small_addr_next_frame", first2, 0);

    // Mid-frame reset at the centre of the visible area.
    found = 0;
    for (int i = 0; i < 1700 && !found; i++) begin
      if (x_s == 20 && y_s == 12) found = 1;
      else @(negedge clk);
    end
    check("mid_found", found, 1);
    check("mid_pre_active", act_s, 1);
    rst_s_n = 1'b0;
    #1;
    check_idle("mid_async", addr_s, x_s, y_s, act_s, hs_s, vs_s, fs_s);
    repeat (3) @(negedge clk);
    check_idle("mid_hold", addr_s, x_s, y_s, act_s, hs_s, vs_s, fs_s);
    release_small("mid");
    scan_small(1650);
    check("mid_fs_count", fs_cnt, 1);
    check("mid_sb_pix", sb_pix, 36 * 20);
    check("mid_sb_bad", sb_bad, 0);
    check("mid_last_addr", last_addr, 44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
